// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: word-addressed program memory, PC, registered IR with
// field split, and branch/jump redirect with a one-cycle squash bubble.
module instr_fetch_unit #(
    parameter int unsigned   IMEM_DEPTH = 256,
    parameter logic [31:0]   RESET_PC   = 32'h0000_0000,
    parameter logic [31:0]   HALT_WORD  = 32'hFC00_0000,
    localparam int unsigned  IMEM_AW    = $clog2(IMEM_DEPTH)
) (
    input  logic               Clock,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [31:0]        prog_data,
    input  logic               start,
    input  logic               stall,
    input  logic               Branch,
    input  logic               Zero,
    input  logic               Jump,
    output logic [31:0]        pc,
    output logic [31:0]        ir_pc,
    output logic [31:0]        instr,
    output logic [5:0]         Inst_31_26,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [5:0]         fn,
    output logic [31:0]        imm_sext,
    output logic               valid,
    output logic               halted
);

    typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [31:0] imem_q [IMEM_DEPTH];
    logic [31:0] fetch_word;
    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    // Program port: writes only while loading; contents survive reset.
    always_ff @(posedge Clock) begin
        if (!reset && state_q == StLoad && prog_we) begin
            imem_q[prog_addr] <= prog_data;
        end
    end

    // Low PC bits are ignored and the index wraps modulo the memory depth.
    assign fetch_word    = imem_q[pc_q[IMEM_AW+1:2]];
    assign pc4           = ir_pc_q + 32'd4;
    assign jump_target   = {pc4[31:28], instr_q[25:0], 2'b00};
    assign branch_target = pc4 + {imm_sext[29:0], 2'b00};

    // Next-state: load/run/halt sequencing, redirect and sequential fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_pc_d = ir_pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        unique case (state_q)
            StLoad: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (!stall) begin
                    if (valid_q && instr_q == HALT_WORD) begin
                        // Halt wins over any Branch/Jump asserted alongside it.
                        state_d = StHalt;
                        valid_d = 1'b0;
                    end else if (valid_q && Jump) begin
                        pc_d    = jump_target;
                        ir_pc_d = jump_target;
                        instr_d = '0;
                        valid_d = 1'b0;
                    end else if (valid_q && Branch && Zero) begin
                        pc_d    = branch_target;
                        ir_pc_d = branch_target;
                        instr_d = '0;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = fetch_word;
                        ir_pc_d = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= StLoad;
            pc_q    <= RESET_PC;
            ir_pc_q <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_pc_q <= ir_pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc         = pc_q;
    assign ir_pc      = ir_pc_q;
    assign instr      = instr_q;
    assign valid      = valid_q;
    assign halted     = (state_q == StHalt);
    assign Inst_31_26 = instr_q[31:26];
    assign rs         = instr_q[25:21];
    assign rt         = instr_q[20:16];
    assign rd         = instr_q[15:11];
    assign fn         = instr_q[5:0];
    assign imm_sext   = {{16{instr_q[15]}}, instr_q[15:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle model built from the fetch/redirect rules,
// checked every cycle, plus hand-computed literal checkpoints.
module tb_instr_fetch_unit;

    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam logic [31:0] ADD  = 32'h0232_4020;
    localparam logic [31:0] BEQ  = 32'h1000_FFFE;
    localparam logic [31:0] JMP  = 32'h0800_0010;
    localparam logic [31:0] JWRAP = 32'h0800_00FF;

    logic        Clock = 1'b0;
    logic        reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic        Jump = 1'b0;
    logic [31:0] pc, ir_pc, instr, imm_sext;
    logic [5:0]  Inst_31_26, fn;
    logic [4:0]  rs, rt, rd;
    logic        valid, halted;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    instr_fetch_unit dut (
        .Clock(Clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .stall(stall), .Branch(Branch),
        .Zero(Zero), .Jump(Jump), .pc(pc), .ir_pc(ir_pc), .instr(instr),
        .Inst_31_26(Inst_31_26), .rs(rs), .rt(rt), .rd(rd), .fn(fn),
        .imm_sext(imm_sext), .valid(valid), .halted(halted)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: 0=load, 1=run, 2=halt.
    int          m_state;
    logic [31:0] m_pc, m_ir_pc, m_instr;
    logic        m_valid;
    logic [31:0] m_mem [256];
    logic [31:0] m_tgt;

    initial for (int i = 0; i < 256; i++) m_mem[i] = '0;

    always @(posedge Clock) begin
        if (reset) begin
            m_state = 0; m_pc = 32'h0; m_ir_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        end else if (m_state == 0) begin
            if (prog_we) m_mem[prog_addr] = prog_data;
            if (start) m_state = 1;
        end else if (m_state == 1 && !stall) begin
            if (m_valid && m_instr == HALT) begin
                m_state = 2;
                m_valid = 1'b0;
            end else if (m_valid && (Jump || (Branch && Zero))) begin
                if (Jump)
                    m_tgt = ((m_ir_pc + 32'd4) & 32'hF000_0000) |
                            ((m_instr & 32'h03FF_FFFF) << 2);
                else
                    m_tgt = m_ir_pc + 32'd4 + 32'($signed(m_instr[15:0])) * 32'd4;
                m_pc = m_tgt; m_ir_pc = m_tgt; m_instr = 32'h0; m_valid = 1'b0;
            end else begin
                m_instr = m_mem[(m_pc / 4) % 256];
                m_ir_pc = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("ir_pc", ir_pc, m_ir_pc);
            chk("instr", instr, m_instr);
            chk("valid", 32'(valid), 32'(m_valid));
            chk("halted", 32'(halted), 32'(m_state == 2));
            chk("opcode", 32'(Inst_31_26), 32'(m_instr[31:26]));
            chk("rs", 32'(rs), 32'(m_instr[25:21]));
            chk("rt", 32'(rt), 32'(m_instr[20:16]));
            chk("rd", 32'(rd), 32'(m_instr[15:11]));
            chk("fn", 32'(fn), 32'(m_instr[5:0]));
            chk("imm_sext", imm_sext, 32'($signed(m_instr[15:0])));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step(1);
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_instr", instr, 32'h0);

        // Fill memory, then place the test program.
        for (int i = 0; i < 256; i++) wr(8'(i), 32'h2000_0000 | 32'(i));
        wr(8'd0, ADD); wr(8'd1, HALT); wr(8'd2, BEQ); wr(8'd3, JMP);

        // add then halt
        start = 1'b1; step(1); start = 1'b0;
        step(1);
        chk("t1_instr", instr, ADD);
        chk("t1_op", 32'(Inst_31_26), 32'd0);
        chk("t1_rs", 32'(rs), 32'd17);
        chk("t1_rt", 32'(rt), 32'd18);
        chk("t1_rd", 32'(rd), 32'd8);
        chk("t1_fn", 32'(fn), 32'h20);
        chk("t1_pc", pc, 32'h4);
        chk("t1_irpc", ir_pc, 32'h0);
        step(1);
        chk("t1_halt_word", instr, HALT);
        Branch = 1'b1; Zero = 1'b1; Jump = 1'b1;
        step(1);
        Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
        chk("t1_halted", 32'(halted), 32'h1);
        chk("t1_hvalid", 32'(valid), 32'h0);
        chk("t1_hpc", pc, 32'h8);
        // prog_we/start/stall ignored in halt
        prog_we = 1'b1; prog_addr = 8'd2; prog_data = 32'hDEAD_BEEF; start = 1'b1; stall = 1'b1;
        step(2);
        prog_we = 1'b0; start = 1'b0; stall = 1'b0;
        chk("t1_hold_pc", pc, 32'h8);

        // Reset out of halt; imem[1] becomes ordinary for branch tests.
        do_reset();
        chk("t2_rst_halted", 32'(halted), 32'h0);
        wr(8'd1, 32'h2000_0001);
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        chk("t2_beq_in_ir", instr, BEQ);
        chk("t2_beq_irpc", ir_pc, 32'h8);
        Branch = 1'b1; Zero = 1'b1;
        step(1);
        Branch = 1'b0; Zero = 1'b0;
        chk("t2_br_pc", pc, 32'h4);
        chk("t2_br_valid", 32'(valid), 32'h0);
        chk("t2_br_instr", instr, 32'h0);
        step(1);
        chk("t2_after_instr", instr, 32'h2000_0001);
        chk("t2_after_irpc", ir_pc, 32'h4);
        step(1);
        Branch = 1'b1; Zero = 1'b0;
        step(1);
        Branch = 1'b0;
        chk("t3_nt_pc", pc, 32'h10);
        chk("t3_nt_valid", 32'(valid), 32'h1);
        chk("t3_nt_instr", instr, JMP);

        // Jump with Branch also asserted: jump wins.
        Jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
        step(1);
        Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        chk("t4_j_pc", pc, 32'h40);
        chk("t4_j_valid", 32'(valid), 32'h0);
        step(1);
        chk("t4_j_instr", instr, 32'h2000_0010);
        chk("t4_j_irpc", ir_pc, 32'h40);

        // Stall three cycles with a program write attempt.
        step(1);
        stall = 1'b1; prog_we = 1'b1; prog_addr = 8'd18; prog_data = 32'hDEAD_BEEF;
        step(3);
        stall = 1'b0; prog_we = 1'b0;
        chk("t5_st_pc", pc, 32'h48);
        chk("t5_st_instr", instr, 32'h2000_0011);
        step(1);
        chk("t5_resume", instr, 32'h2000_0012);

        // Reset mid-run, re-execute, then jump to the top for the wrap.
        do_reset();
        chk("t6_pc", pc, 32'h0);
        chk("t6_valid", 32'(valid), 32'h0);
        wr(8'd4, JWRAP);
        start = 1'b1; step(1); start = 1'b0;
        step(1);
        chk("t6_reexec", instr, ADD);
        step(4);
        chk("t7_jw_in_ir", instr, JWRAP);
        Jump = 1'b1;
        step(1);
        Jump = 1'b0;
        chk("t7_pc_top", pc, 32'h3FC);
        step(1);
        chk("t7_top_instr", instr, 32'h2000_00FF);
        step(1);
        chk("t7_wrap_instr", instr, ADD);
        chk("t7_wrap_irpc", ir_pc, 32'h400);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage that feeds the control unit, ALU control and register file of the MIPS datapath. It holds a word-addressed instruction memory loaded over a program port and a PC register. Each running cycle it fetches into a registered instruction register (IR) and splits IR into opcode, rs, rt, rd, funct and sign-extended immediate. It resolves branches and jumps from downstream Branch/Zero/Jump by redirecting the PC and squashing the wrong-path fetch.

Parameters:
IMEM_DEPTH, 256, instruction memory depth in 32-bit words; power of two.
RESET_PC, 32'h00000000, PC value after reset.
HALT_WORD, 32'hFC000000, instruction encoding (opcode 63) that stops fetch.

Ports:
Clock  input  1  rising-edge clock.
reset  input  1  reset, synchronous, active-high; clock Clock.
prog_we  input  1  program write strobe; honoured only in LOAD.
prog_addr  input  log2(IMEM_DEPTH)  word index for program write.
prog_data  input  32  instruction word to write.
start  input  1  one-cycle pulse: LOAD -> RUN.
stall  input  1  hold PC, IR and valid this cycle.
Branch  input  1  from control; IR is a branch.
Zero  input  1  from ALU; branch condition true.
Jump  input  1  from control; IR is a J-type jump.
pc  output  32  address of next fetch.
ir_pc  output  32  address of the instruction currently in IR.
instr  output  32  IR contents.
Inst_31_26  output  6  instr[31:26].
rs, rt, rd  output  5 each  instr[25:21], [20:16], [15:11].
fn  output  6  instr[5:0].
imm_sext  output  32  {{16{instr[15]}}, instr[15:0]}.
valid  output  1  IR holds a live instruction.
halted  output  1  state == HALT.

Behaviour:
- States: LOAD, RUN, HALT. All registers update on posedge Clock only.
- Reset (dominates every other input, any state): state=LOAD, pc=RESET_PC, ir_pc=0, instr=0, valid=0, halted=0. imem contents are not cleared.
- LOAD:
  - prog_we=1 writes imem[prog_addr]=prog_data.
  - start=1 moves to RUN next cycle. prog_we and start in the same cycle: the write is performed and the transition is taken.
  - pc, instr and valid are held.
- RUN with stall=1: pc, ir_pc, instr, valid and state are all held. Branch, Jump and halt detection are not evaluated.
- RUN with stall=0, redirect decided from current IR, only when valid=1:
  - jump_taken = Jump.
  - branch_taken = Branch & Zero & ~Jump. Jump has priority.
  - pc4 = ir_pc + 4.
  - Jump target = {pc4[31:28], instr[25:0], 2'b00}.
  - Branch target = pc4 + (imm_sext << 2), modulo 2^32.
- Redirect taken: pc <= target; instr <= 0; valid <= 0 (one-cycle bubble squashing the wrong-path fetch); ir_pc <= target.
- Otherwise (sequential fetch): instr <= imem[pc[log2(IMEM_DEPTH)+1:2]]; ir_pc <= pc; valid <= 1; pc <= pc + 4.
- Latency: PC to instr is 1 cycle. A taken branch or jump costs 1 bubble cycle.
- Address wrap: word index uses pc[log2(IMEM_DEPTH)+1:2] only, so fetches past the top wrap modulo IMEM_DEPTH. PC arithmetic wraps at 2^32. pc[1:0] are ignored for fetch.
- Halt: if valid=1, stall=0 and instr==HALT_WORD, then next cycle state=HALT, halted=1, valid=0, and pc is held.
  - HALT_WORD is never treated as a branch or jump even if Branch/Jump are asserted.
  - HALT is left only by reset. start, prog_we and stall are ignored in HALT.
- prog_we in RUN or HALT is ignored; imem is unchanged.
- Field outputs are continuous slices of instr. With valid=0 they show the current instr value (0 after a bubble, i.e. opcode 0 / funct 0). Downstream must gate Reg_Write with valid.

Test Plan:
- Reset then load: write imem[0]=32'h02324020 (add $8,$17,$18), imem[1]=HALT_WORD, pulse start -> cycle after RUN: instr=32'h02324020, Inst_31_26=0, rs=17, rt=18, rd=8, fn=6'h20, valid=1, ir_pc=0, pc=4. Next cycle: instr=HALT_WORD. Following cycle: halted=1, valid=0, pc=8 held.
- Branch taken: imem[2]=beq with imm=16'hFFFE at ir_pc=8, Branch=1, Zero=1 -> next cycle pc=32'h00000004, valid=0. Cycle after: instr=imem[1], ir_pc=4.
- Branch not taken: same instruction with Zero=0 -> no bubble; pc advances 8->12->16 and valid stays 1.
- Jump: imem[3]=32'h08000010 with Jump=1 and Branch=1 -> pc=32'h00000040 (jump wins), one bubble, then instr=imem[16].
- Stall: stall=1 for 3 cycles mid-program -> pc, instr, ir_pc and valid are unchanged. Release -> sequence resumes with no skipped or duplicated instruction. prog_we during RUN leaves imem unchanged.
- Reset mid-RUN and in HALT: reset=1 at pc=32'h20 -> next cycle pc=0, valid=0, halted=0, state LOAD. Program is still present, so start re-executes imem[0]. PC wrap with IMEM_DEPTH=256: pc=32'h3FC fetches imem[255], then pc=32'h400 fetches imem[0].
